// File: rtl/rv32iv_isa_pkg.sv
// Shared RV32I+vector ISA definitions: instruction classes, opcodes,
// immediate formats and shift funct7 values (shared with the decoder).
package rv32iv_isa_pkg;

    typedef enum logic [3:0] {
        CLS_R    = 4'd0,
        CLS_IA   = 4'd1,
        CLS_IL   = 4'd2,
        CLS_S    = 4'd3,
        CLS_B    = 4'd4,
        CLS_J    = 4'd5,
        CLS_IJ   = 4'd6,
        CLS_U    = 4'd7,
        CLS_U_PC = 4'd8,
        CLS_IT   = 4'd9,
        CLS_VR   = 4'd10,
        CLS_ST   = 4'd11,
        CLS_VT   = 4'd12,
        CLS_SV   = 4'd13,
        CLS_LV   = 4'd14,
        CLS_VA   = 4'd15
    } instr_class_t;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_t;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_IA   = 7'b0010011;
    localparam logic [6:0] OPC_IL   = 7'b0000011;
    localparam logic [6:0] OPC_S    = 7'b0100011;
    localparam logic [6:0] OPC_B    = 7'b1100011;
    localparam logic [6:0] OPC_J    = 7'b1101111;
    localparam logic [6:0] OPC_IJ   = 7'b1100111;
    localparam logic [6:0] OPC_U    = 7'b0110111;
    localparam logic [6:0] OPC_U_PC = 7'b0010111;
    localparam logic [6:0] OPC_IT   = 7'b1110011;
    localparam logic [6:0] OPC_VR   = 7'b1010111;
    localparam logic [6:0] OPC_ST   = 7'b0101111;
    localparam logic [6:0] OPC_VT   = 7'b1011011;
    localparam logic [6:0] OPC_SV   = 7'b0100111;
    localparam logic [6:0] OPC_LV   = 7'b0000111;
    localparam logic [6:0] OPC_VA   = 7'b0001011;

    localparam logic [6:0] F7_SHIFT_LOGIC = 7'h00;
    localparam logic [6:0] F7_SHIFT_ARITH = 7'h20;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_packer_rv32iv.sv
// Places an immediate into its instruction-word bit positions for the
// given format and reports whether the value is encodable without loss.
module imm_packer_rv32iv
    import rv32iv_isa_pkg::*;
(
    input  imm_fmt_t    fmt,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_ok
);

    logic fits12;
    logic fits13;
    logic fits21;

    // value fits when all bits above the field's sign bit equal it
    assign fits12 = (&imm[31:11]) || !(|imm[31:11]);
    assign fits13 = (&imm[31:12]) || !(|imm[31:12]);
    assign fits21 = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        word     = '0;
        range_ok = 1'b1;
        case (fmt)
            FMT_I: begin
                word[31:20] = imm[11:0];
                range_ok    = fits12;
            end
            FMT_S: begin
                word[31:25] = imm[11:5];
                word[11:7]  = imm[4:0];
                range_ok    = fits12;
            end
            FMT_B: begin
                word[31]    = imm[12];
                word[30:25] = imm[10:5];
                word[11:8]  = imm[4:1];
                word[7]     = imm[11];
                range_ok    = fits13 && !imm[0];
            end
            FMT_U: begin
                word[31:12] = imm[31:12];
                range_ok    = (imm[11:0] == 12'h000);
            end
            FMT_J: begin
                word[31]    = imm[20];
                word[30:21] = imm[10:1];
                word[20]    = imm[11];
                word[19:12] = imm[19:12];
                range_ok    = fits21 && !imm[0];
            end
            default: begin
                word     = '0;
                range_ok = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encoder_rv32iv.sv
// Packs field descriptors into RV32I+vector words behind a one-stage
// valid/ready register. Define ENC_IMM_CHECK_EN for immediate checking.
module instruction_encoder_rv32iv
    import rv32iv_isa_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int BASE_ADDR  = 0,
    parameter int IMEM_BYTES = 4096
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_f3,
    input  logic [6:0]        in_f7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_pulse,
    output logic              err_sticky,
    input  logic              err_clear,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(IMEM_BYTES - 1);

    instr_class_t      cls;
    imm_fmt_t          fmt;
    logic [6:0]        opc;
    logic              class_ok;
    logic              is_shift;
    logic [31:0]       imm_eff;
    logic [31:0]       imm_word;
    logic              range_ok;
    logic [31:0]       enc;
    logic              reject;
    logic              acc;
    logic              out_hs;
    logic [ADDR_W-1:0] next_addr;

    assign cls = instr_class_t'(in_class);

    always_comb begin
        fmt      = FMT_R;
        opc      = OPC_R;
        class_ok = 1'b1;
        case (cls)
            CLS_R:    begin fmt = FMT_R; opc = OPC_R;    end
            CLS_IA:   begin fmt = FMT_I; opc = OPC_IA;   end
            CLS_IL:   begin fmt = FMT_I; opc = OPC_IL;   end
            CLS_S:    begin fmt = FMT_S; opc = OPC_S;    end
            CLS_B:    begin fmt = FMT_B; opc = OPC_B;    end
            CLS_J:    begin fmt = FMT_J; opc = OPC_J;    end
            CLS_IJ:   begin fmt = FMT_I; opc = OPC_IJ;   end
            CLS_U:    begin fmt = FMT_U; opc = OPC_U;    end
            CLS_U_PC: begin fmt = FMT_U; opc = OPC_U_PC; end
            CLS_IT:   begin fmt = FMT_I; opc = OPC_IT;   end
            CLS_VR:   begin fmt = FMT_R; opc = OPC_VR;   end
            CLS_ST:   begin fmt = FMT_R; opc = OPC_ST;   end
            CLS_VT:   begin fmt = FMT_R; opc = OPC_VT;   end
            CLS_SV:   begin fmt = FMT_S; opc = OPC_SV;   end
            CLS_LV:   begin fmt = FMT_I; opc = OPC_LV;   end
            CLS_VA:   begin fmt = FMT_R; opc = OPC_VA;   end
            default:  class_ok = 1'b0;
        endcase
    end

    assign is_shift = (cls == CLS_IA) &&
                      ((in_f3 == F3_SLL) || (in_f3 == F3_SRX));

    // shift immediates carry funct7 in the upper immediate bits
    assign imm_eff = is_shift ? {20'b0, in_f7, in_imm[4:0]} : in_imm;

    imm_packer_rv32iv u_imm_packer (
        .fmt      (fmt),
        .imm      (imm_eff),
        .word     (imm_word),
        .range_ok (range_ok)
    );

    always_comb begin
        enc       = imm_word;
        enc[6:0]  = opc;
        case (fmt)
            FMT_R: begin
                enc[31:25] = in_f7;
                enc[24:20] = in_rs2;
                enc[19:15] = in_rs1;
                enc[14:12] = in_f3;
                enc[11:7]  = in_rd;
            end
            FMT_I: begin
                enc[19:15] = in_rs1;
                enc[14:12] = in_f3;
                enc[11:7]  = in_rd;
            end
            FMT_S, FMT_B: begin
                enc[24:20] = in_rs2;
                enc[19:15] = in_rs1;
                enc[14:12] = in_f3;
            end
            FMT_U, FMT_J: begin
                enc[11:7]  = in_rd;
            end
            default: ;
        endcase
    end

    assign in_ready  = (!out_valid || out_ready) && !flush;
    assign acc       = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign next_addr = (out_addr + ADDR_W'(4)) & WRAP_MASK;

`ifdef ENC_IMM_CHECK_EN
    logic shift_ok;
    logic rej_evt;

    assign shift_ok = (in_imm[31:5] == 27'd0) &&
                      ((in_f7 == F7_SHIFT_LOGIC) ||
                       ((in_f7 == F7_SHIFT_ARITH) && (in_f3 == F3_SRX)));
    assign reject   = !class_ok || !range_ok || (is_shift && !shift_ok);
    assign rej_evt  = acc && reject;

    // clear wins over a same-cycle rejection, which then counts as the first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            err_pulse <= rej_evt;
            if (err_clear) begin
                err_sticky <= rej_evt;
                err_count  <= rej_evt ? 8'd1 : 8'd0;
            end else if (rej_evt) begin
                err_sticky <= 1'b1;
                if (err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end
        end
    end
`else
    logic [2:0] unused_chk;

    assign unused_chk = {class_ok, range_ok, err_clear};
    assign reject     = 1'b0;
    assign err_pulse  = 1'b0;
    assign err_sticky = 1'b0;
    assign err_count  = 8'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_addr  <= BASE;
        end else begin
            if (out_hs)
                out_addr <= next_addr;
            if (acc && !reject) begin
                out_valid <= 1'b1;
                out_instr <= enc;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder_rv32iv.sv
// Directed bench for instruction_encoder_rv32iv: encodings, throughput,
// stalls, rejection, address wrap, flush and async reset.
module tb_instruction_encoder_rv32iv;
    import rv32iv_isa_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_class;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_f3;
    logic [6:0]  in_f7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [11:0] out_addr;
    logic        err_pulse;
    logic        err_sticky;
    logic        err_clear;
    logic [7:0]  err_count;

    int          n_vec;
    int          n_bad;
    logic [11:0] exp_addr;

    instruction_encoder_rv32iv #(
        .ADDR_W     (12),
        .BASE_ADDR  (0),
        .IMEM_BYTES (4096)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_f3      (in_f3),
        .in_f7      (in_f7),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_clear  (err_clear),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] c, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        in_class = c;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_f3    = f3;
        in_f7    = f7;
        in_imm   = imm;
        in_valid = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_vec++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr got %h want 0", out_instr); end
        n_vec++; if (out_addr !== 12'h000) begin n_bad++; $display("FAIL reset_addr got %h want 000", out_addr); end
        n_vec++; if ({err_pulse, err_sticky, err_count} !== 10'd0) begin n_bad++; $display("FAIL reset_err got %b/%b/%0d want 0", err_pulse, err_sticky, err_count); end
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_encode;
        logic [3:0]  c   [5];
        logic [4:0]  rd  [5];
        logic [4:0]  rs1 [5];
        logic [4:0]  rs2 [5];
        logic [2:0]  f3  [5];
        logic [31:0] imm [5];
        logic [31:0] exp [5];
        c   = '{CLS_IA, CLS_S, CLS_B, CLS_J, CLS_U};
        rd  = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd5};
        rs1 = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd0};
        rs2 = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd0};
        f3  = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
        imm = '{32'd5, 32'd8, -32'sd4, 32'd2048, 32'h12345000};
        exp = '{32'h00500093, 32'h0020A423, 32'hFE000EE3,
                32'h001000EF, 32'h123452B7};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(c[i], rd[i], rs1[i], rs2[i], f3[i], 7'd0, imm[i]);
            tick();
            n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL enc%0d_valid got %b want 1", i, out_valid); end
            n_vec++; if (out_instr !== exp[i]) begin n_bad++; $display("FAIL enc%0d_instr got %h want %h", i, out_instr, exp[i]); end
            n_vec++; if (out_addr !== exp_addr) begin n_bad++; $display("FAIL enc%0d_addr got %h want %h", i, out_addr, exp_addr); end
            exp_addr += 12'd4;
        end
        in_valid = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b0 || out_addr !== exp_addr) begin n_bad++; $display("FAIL enc_idle got %b/%h want 0/%h", out_valid, out_addr, exp_addr); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(CLS_IA, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
            tick();
            w = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
            n_vec++; if (out_valid !== 1'b1 || out_instr !== w || out_addr !== exp_addr) begin n_bad++; $display("FAIL b2b%0d got %b/%h@%h want 1/%h@%h", i, out_valid, out_instr, out_addr, w, exp_addr); end
            if (i < 3) exp_addr += 12'd4;
        end
        out_ready = 1'b0;
        drive(CLS_IA, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall%0d_in_ready got %b want 0", i, in_ready); end
            n_vec++; if (out_valid !== 1'b1 || out_instr !== w || out_addr !== exp_addr) begin n_bad++; $display("FAIL stall%0d_hold got %b/%h@%h want 1/%h@%h", i, out_valid, out_instr, out_addr, w, exp_addr); end
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got %b want 1", in_ready); end
        tick();
        exp_addr += 12'd4;
        n_vec++; if (out_valid !== 1'b1 || out_instr !== 32'h06400493 || out_addr !== exp_addr) begin n_bad++; $display("FAIL release_word got %b/%h@%h want 1/06400493@%h", out_valid, out_instr, out_addr, exp_addr); end
        in_valid = 1'b0;
        tick();
        exp_addr += 12'd4;
        n_vec++; if (out_valid !== 1'b0 || out_addr !== exp_addr) begin n_bad++; $display("FAIL b2b_drain got %b/%h want 0/%h", out_valid, out_addr, exp_addr); end
    endtask

    task automatic test_errors;
        out_ready = 1'b1;
`ifdef ENC_IMM_CHECK_EN
        drive(CLS_IA, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        tick();
        n_vec++; if (out_valid !== 1'b0 || err_pulse !== 1'b1 || err_count !== 8'd1) begin n_bad++; $display("FAIL rej_addi got v%b p%b c%0d want v0 p1 c1", out_valid, err_pulse, err_count); end
        drive(CLS_B, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        tick();
        n_vec++; if (out_valid !== 1'b0 || err_pulse !== 1'b1 || err_count !== 8'd2 || err_sticky !== 1'b1) begin n_bad++; $display("FAIL rej_beq got v%b p%b c%0d s%b want v0 p1 c2 s1", out_valid, err_pulse, err_count, err_sticky); end
        in_valid = 1'b0;
        tick();
        n_vec++; if (err_pulse !== 1'b0 || out_addr !== exp_addr || out_valid !== 1'b0) begin n_bad++; $display("FAIL rej_after got p%b a%h v%b want p0 a%h v0", err_pulse, out_addr, out_valid, exp_addr); end
        err_clear = 1'b1;
        tick();
        n_vec++; if (err_count !== 8'd0 || err_sticky !== 1'b0) begin n_bad++; $display("FAIL err_clear got c%0d s%b want c0 s0", err_count, err_sticky); end
        drive(CLS_IA, 5'd1, 5'd2, 5'd0, 3'd1, 7'h20, 32'd3);
        tick();
        err_clear = 1'b0;
        n_vec++; if (err_count !== 8'd1 || err_sticky !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL clear_and_reject got c%0d s%b v%b want c1 s1 v0", err_count, err_sticky, out_valid); end
`else
        drive(CLS_IA, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        tick();
        n_vec++; if (out_valid !== 1'b1 || out_instr !== 32'h80000093 || out_addr !== exp_addr) begin n_bad++; $display("FAIL trunc_addi got %b/%h@%h want 1/80000093@%h", out_valid, out_instr, out_addr, exp_addr); end
        exp_addr += 12'd4;
        drive(CLS_B, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        tick();
        n_vec++; if (out_instr !== 32'h00000163 || out_addr !== exp_addr) begin n_bad++; $display("FAIL trunc_beq got %h@%h want 00000163@%h", out_instr, out_addr, exp_addr); end
        exp_addr += 12'd4;
        err_clear = 1'b1;
        drive(CLS_IA, 5'd1, 5'd2, 5'd0, 3'd1, 7'h20, 32'd3);
        tick();
        err_clear = 1'b0;
        n_vec++; if (out_instr !== 32'h40311093 || out_addr !== exp_addr) begin n_bad++; $display("FAIL trunc_slli got %h@%h want 40311093@%h", out_instr, out_addr, exp_addr); end
        n_vec++; if ({err_pulse, err_sticky, err_count} !== 10'd0) begin n_bad++; $display("FAIL err_tied got %b/%b/%0d want 0", err_pulse, err_sticky, err_count); end
        exp_addr += 12'd4;
`endif
        drive(CLS_IA, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3);
        tick();
        n_vec++; if (out_valid !== 1'b1 || out_instr !== 32'h40315093 || out_addr !== exp_addr) begin n_bad++; $display("FAIL srai got %b/%h@%h want 1/40315093@%h", out_valid, out_instr, out_addr, exp_addr); end
        exp_addr += 12'd4;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_wrap;
        int n;
        n = (4096 - int'(exp_addr)) / 4;
        out_ready = 1'b1;
        drive(CLS_IA, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        for (int k = 0; k < n; k++) tick();
        n_vec++; if (out_valid !== 1'b1 || out_addr !== 12'hFFC || out_instr !== 32'h00000013) begin n_bad++; $display("FAIL wrap_last got %b/%h@%h want 1/00000013@ffc", out_valid, out_instr, out_addr); end
        in_valid = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b0 || out_addr !== 12'h000) begin n_bad++; $display("FAIL wrap_zero got %b/%h want 0/000", out_valid, out_addr); end
        exp_addr = 12'h000;
    endtask

    task automatic test_flush;
        out_ready = 1'b1;
        drive(CLS_IA, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b1 || out_addr !== 12'h004) begin n_bad++; $display("FAIL flush_pre got %b/%h want 1/004", out_valid, out_addr); end
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(CLS_IA, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || out_addr !== 12'h000) begin n_bad++; $display("FAIL flush_post got %b/%h want 0/000", out_valid, out_addr); end
        tick();
        n_vec++; if (out_valid !== 1'b1 || out_instr !== 32'h00700193 || out_addr !== 12'h000) begin n_bad++; $display("FAIL flush_next got %b/%h@%h want 1/00700193@000", out_valid, out_instr, out_addr); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        drive(CLS_IA, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_instr !== 32'h00100113 || out_addr !== 12'h004) begin n_bad++; $display("FAIL ares_pre got %b/%h@%h want 1/00100113@004", out_valid, out_instr, out_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 12'h000) begin n_bad++; $display("FAIL ares_out got %b/%h@%h want 0/00000000@000", out_valid, out_instr, out_addr); end
        n_vec++; if ({err_pulse, err_sticky, err_count} !== 10'd0) begin n_bad++; $display("FAIL ares_err got %b/%b/%0d want 0", err_pulse, err_sticky, err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b0 || out_addr !== 12'h000) begin n_bad++; $display("FAIL ares_post got %b/%h want 0/000", out_valid, out_addr); end
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        exp_addr  = 12'h000;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_class  = 4'd0;
        in_rd     = 5'd0;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_f3     = 3'd0;
        in_f7     = 7'd0;
        in_imm    = 32'd0;
        out_ready = 1'b0;
        err_clear = 1'b0;
        test_reset();
        test_encode();
        test_back_to_back();
        test_errors();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
